// File: rtl/count_frame_collector.sv
// Photon-count frame collector: bins per gate window into ping-pong buffers, streams frames.
// Optional macro FRAME_SUM_EN enables the saturating frame photon sum.
module count_frame_collector #(
   parameter int NUM_BINS = 16,
   parameter int SUM_W    = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             INTR,
   input  logic [7:0]       COUNTER,
   input  logic             CLEAR,
   output logic [7:0]       M_DATA,
   output logic             M_VALID,
   input  logic             M_READY,
   output logic             M_LAST,
   output logic [8:0]       FRAME_BINS,
   output logic             FRAME_OVF,
   output logic [SUM_W-1:0] FRAME_SUM,
   output logic [7:0]       DROP_CNT
);

   localparam int IW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
   localparam int CW = IW + 1;

   typedef enum logic {EMPTY, STREAM} rd_state_t;

   rd_state_t      state, state_d;
   logic           intr_d, clear_d;
   logic           bin_ev, end_ev;
   logic           cap, close, busy;
   logic           wr_sel;
   logic [CW-1:0]  wr_idx, bins_n, fbins;
   logic           wr_ovf, ovf_n, fovf;
   logic [IW-1:0]  rd_idx, rd_idx_d;
   logic [7:0]     drop_cnt;
   logic [7:0]     mem [2][NUM_BINS];

   assign bin_ev = INTR & ~intr_d;
   assign end_ev = CLEAR & ~clear_d;
   assign cap    = bin_ev & (wr_idx < CW'(NUM_BINS));
   // Next write-side state already includes a bin arriving with the frame end
   assign bins_n = wr_idx + CW'(cap);
   assign ovf_n  = wr_ovf | (bin_ev & ~cap);
   assign close  = end_ev & ((bins_n != '0) | ovf_n);
   assign busy   = (state == STREAM);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         intr_d   <= 1'b0;
         clear_d  <= 1'b0;
         wr_sel   <= 1'b0;
         wr_idx   <= '0;
         wr_ovf   <= 1'b0;
         fbins    <= '0;
         fovf     <= 1'b0;
         drop_cnt <= '0;
         state    <= EMPTY;
         rd_idx   <= '0;
      end else begin
         intr_d  <= INTR;
         clear_d <= CLEAR;
         state   <= state_d;
         rd_idx  <= rd_idx_d;
         if (end_ev) begin
            wr_idx <= '0;
            wr_ovf <= 1'b0;
         end else begin
            wr_idx <= bins_n;
            wr_ovf <= ovf_n;
         end
         if (close & ~busy) begin
            wr_sel <= ~wr_sel;
            fbins  <= bins_n;
            fovf   <= ovf_n;
         end
         if (close & busy & (drop_cnt != 8'hff))
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_N && cap)
         mem[wr_sel][wr_idx[IW-1:0]] <= COUNTER;
   end

   always_comb begin
      state_d  = state;
      rd_idx_d = rd_idx;
      M_VALID  = 1'b0;
      M_LAST   = 1'b0;
      M_DATA   = '0;
      unique case (state)
         EMPTY: begin
            if (close) begin
               state_d  = STREAM;
               rd_idx_d = '0;
            end
         end
         STREAM: begin
            M_VALID = 1'b1;
            M_LAST  = (rd_idx == IW'(NUM_BINS - 1));
            // Beats past the captured bin count are zero padding
            if ({1'b0, rd_idx} < fbins)
               M_DATA = mem[~wr_sel][rd_idx];
            if (M_READY) begin
               if (M_LAST)
                  state_d = EMPTY;
               else
                  rd_idx_d = rd_idx + 1'b1;
            end
         end
      endcase
   end

`ifdef FRAME_SUM_EN
   logic [SUM_W-1:0] acc, acc_n, fsum;
   logic [SUM_W:0]   acc_add;

   assign acc_add = {1'b0, acc} + (SUM_W+1)'(bin_ev ? COUNTER : 8'd0);
   assign acc_n   = acc_add[SUM_W] ? '1 : acc_add[SUM_W-1:0];

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         acc  <= '0;
         fsum <= '0;
      end else begin
         acc <= end_ev ? '0 : acc_n;
         if (close & ~busy)
            fsum <= acc_n;
      end
   end

   assign FRAME_SUM = fsum;
`else
   assign FRAME_SUM = '0;
`endif

   assign FRAME_BINS = 9'(fbins);
   assign FRAME_OVF  = fovf;
   assign DROP_CNT   = drop_cnt;

endmodule

// File: tb/tb_count_frame_collector.sv
// Directed bench for count_frame_collector: frame capture, padding, overflow,
// drop, same-cycle bin/end, ready backpressure and mid-stream reset.
module tb_count_frame_collector;

`ifdef FRAME_SUM_EN
   localparam bit SUM_ON = 1'b1;
`else
   localparam bit SUM_ON = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        INTR = 1'b0;
   logic [7:0]  COUNTER = '0;
   logic        CLEAR = 1'b0;
   logic [7:0]  M_DATA;
   logic        M_VALID;
   logic        M_READY = 1'b0;
   logic        M_LAST;
   logic [8:0]  FRAME_BINS;
   logic        FRAME_OVF;
   logic [15:0] FRAME_SUM;
   logic [7:0]  DROP_CNT;

   int tests = 0;
   int fails = 0;

   logic [7:0] got_data [64];
   logic       got_last [64];
   int         got_n;
   int         hold_err;

   count_frame_collector #(.NUM_BINS(16), .SUM_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .COUNTER(COUNTER),
      .CLEAR(CLEAR), .M_DATA(M_DATA), .M_VALID(M_VALID),
      .M_READY(M_READY), .M_LAST(M_LAST), .FRAME_BINS(FRAME_BINS),
      .FRAME_OVF(FRAME_OVF), .FRAME_SUM(FRAME_SUM), .DROP_CNT(DROP_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic pulse_intr(input logic [7:0] v);
      @(negedge CLK);
      INTR = 1'b1;
      COUNTER = v;
      @(negedge CLK);
      INTR = 1'b0;
   endtask

   // Returns at the negedge where the first beat is visible
   task automatic close_frame();
      @(negedge CLK);
      CLEAR = 1'b1;
      @(negedge CLK);
      CLEAR = 1'b0;
   endtask

   // mode 0: ready held high; mode 1: ready toggles 1/0 each cycle
   task automatic collect(input int mode);
      logic [7:0] pd;
      logic       pl;
      bit         stalled;
      bit         done;
      got_n = 0;
      hold_err = 0;
      stalled = 1'b0;
      done = 1'b0;
      pd = '0;
      pl = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         M_READY = (mode == 0) ? 1'b1 : ((c % 2) == 0);
         if (stalled && M_VALID && (M_DATA !== pd || M_LAST !== pl))
            hold_err++;
         if (M_VALID && M_READY && got_n < 64) begin
            got_data[got_n] = M_DATA;
            got_last[got_n] = M_LAST;
            got_n++;
            if (M_LAST === 1'b1) done = 1'b1;
         end
         stalled = M_VALID && !M_READY;
         pd = M_DATA;
         pl = M_LAST;
         @(negedge CLK);
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL stream_timeout: got %0d beats, required a beat with last", got_n);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      tests++; if (M_VALID !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", M_VALID); end
      tests++; if (M_LAST !== 1'b0) begin fails++; $display("FAIL rst_last: got %b want 0", M_LAST); end
      tests++; if (M_DATA !== 8'd0) begin fails++; $display("FAIL rst_data: got %0d want 0", M_DATA); end
      tests++; if (FRAME_BINS !== 9'd0) begin fails++; $display("FAIL rst_bins: got %0d want 0", FRAME_BINS); end
      tests++; if (FRAME_OVF !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b want 0", FRAME_OVF); end
      tests++; if (FRAME_SUM !== 16'd0) begin fails++; $display("FAIL rst_sum: got %0d want 0", FRAME_SUM); end
      tests++; if (DROP_CNT !== 8'd0) begin fails++; $display("FAIL rst_drop: got %0d want 0", DROP_CNT); end
   endtask

   task automatic test_basic();
      logic [7:0] exp;
      pulse_intr(8'd5);
      pulse_intr(8'd7);
      pulse_intr(8'd9);
      close_frame();
      tests++; if (M_VALID !== 1'b1) begin fails++; $display("FAIL basic_latency: valid %b want 1", M_VALID); end
      tests++; if (FRAME_BINS !== 9'd3) begin fails++; $display("FAIL basic_bins: got %0d want 3", FRAME_BINS); end
      tests++; if (FRAME_OVF !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b want 0", FRAME_OVF); end
      tests++; if (FRAME_SUM !== (SUM_ON ? 16'd21 : 16'd0)) begin fails++; $display("FAIL basic_sum: got %0d want %0d", FRAME_SUM, SUM_ON ? 21 : 0); end
      collect(0);
      tests++; if (got_n !== 16) begin fails++; $display("FAIL basic_count: got %0d want 16", got_n); end
      for (int i = 0; i < 16; i++) begin
         exp = (i == 0) ? 8'd5 : (i == 1) ? 8'd7 : (i == 2) ? 8'd9 : 8'd0;
         tests++;
         if (got_data[i] !== exp || got_last[i] !== (i == 15)) begin
            fails++;
            $display("FAIL basic_beat%0d: got %0d/%b want %0d/%b", i, got_data[i], got_last[i], exp, i == 15);
         end
      end
      tests++; if (M_VALID !== 1'b0) begin fails++; $display("FAIL basic_end_valid: got %b want 0", M_VALID); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 18; i++) pulse_intr(8'd1);
      close_frame();
      tests++; if (FRAME_BINS !== 9'd16) begin fails++; $display("FAIL ovf_bins: got %0d want 16", FRAME_BINS); end
      tests++; if (FRAME_OVF !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", FRAME_OVF); end
      tests++; if (FRAME_SUM !== (SUM_ON ? 16'd18 : 16'd0)) begin fails++; $display("FAIL ovf_sum: got %0d want %0d", FRAME_SUM, SUM_ON ? 18 : 0); end
      collect(0);
      tests++; if (got_n !== 16) begin fails++; $display("FAIL ovf_count: got %0d want 16", got_n); end
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (got_data[i] !== 8'd1) begin fails++; $display("FAIL ovf_beat%0d: got %0d want 1", i, got_data[i]); end
      end
   endtask

   task automatic test_drop();
      M_READY = 1'b0;
      pulse_intr(8'd3);
      pulse_intr(8'd4);
      close_frame();
      pulse_intr(8'd8);
      close_frame();
      tests++; if (DROP_CNT !== 8'd1) begin fails++; $display("FAIL drop_cnt: got %0d want 1", DROP_CNT); end
      tests++; if (FRAME_BINS !== 9'd2) begin fails++; $display("FAIL drop_bins: got %0d want 2", FRAME_BINS); end
      collect(0);
      tests++; if (got_n !== 16) begin fails++; $display("FAIL drop_count: got %0d want 16", got_n); end
      tests++; if (got_data[0] !== 8'd3 || got_data[1] !== 8'd4 || got_data[2] !== 8'd0) begin
         fails++; $display("FAIL drop_data: got %0d,%0d,%0d want 3,4,0", got_data[0], got_data[1], got_data[2]);
      end
      repeat (3) @(negedge CLK);
      tests++; if (M_VALID !== 1'b0) begin fails++; $display("FAIL drop_no_second: valid %b want 0", M_VALID); end
   endtask

   task automatic test_empty_close();
      close_frame();
      repeat (2) @(negedge CLK);
      tests++; if (M_VALID !== 1'b0) begin fails++; $display("FAIL empty_valid: got %b want 0", M_VALID); end
      tests++; if (DROP_CNT !== 8'd1) begin fails++; $display("FAIL empty_drop: got %0d want 1", DROP_CNT); end
   endtask

   task automatic test_simultaneous();
      pulse_intr(8'd1);
      pulse_intr(8'd2);
      @(negedge CLK);
      INTR = 1'b1;
      COUNTER = 8'd4;
      CLEAR = 1'b1;
      @(negedge CLK);
      INTR = 1'b0;
      CLEAR = 1'b0;
      tests++; if (FRAME_BINS !== 9'd3) begin fails++; $display("FAIL simul_bins: got %0d want 3", FRAME_BINS); end
      collect(0);
      tests++; if (got_data[2] !== 8'd4) begin fails++; $display("FAIL simul_beat3: got %0d want 4", got_data[2]); end
      tests++; if (got_data[0] !== 8'd1 || got_data[1] !== 8'd2) begin
         fails++; $display("FAIL simul_head: got %0d,%0d want 1,2", got_data[0], got_data[1]);
      end
   endtask

   task automatic test_ready_toggle();
      for (int i = 0; i < 16; i++) pulse_intr(8'(i * 3 + 1));
      close_frame();
      collect(1);
      tests++; if (got_n !== 16) begin fails++; $display("FAIL toggle_count: got %0d want 16", got_n); end
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (got_data[i] !== 8'(i * 3 + 1)) begin fails++; $display("FAIL toggle_beat%0d: got %0d want %0d", i, got_data[i], i * 3 + 1); end
      end
      tests++; if (hold_err !== 0) begin fails++; $display("FAIL toggle_hold: got %0d unstable stalls want 0", hold_err); end
   endtask

   task automatic test_reset_mid_stream();
      M_READY = 1'b0;
      pulse_intr(8'h99);
      pulse_intr(8'h99);
      close_frame();
      pulse_intr(8'h77);
      close_frame();
      tests++; if (DROP_CNT !== 8'd2) begin fails++; $display("FAIL mid_pre_drop: got %0d want 2", DROP_CNT); end
      M_READY = 1'b1;
      repeat (16) @(negedge CLK);
      M_READY = 1'b0;
      for (int i = 0; i < 6; i++) pulse_intr(8'h11 * (i + 1));
      close_frame();
      M_READY = 1'b1;
      repeat (4) @(negedge CLK);
      tests++; if (M_DATA !== 8'h55) begin fails++; $display("FAIL mid_beat5: got %0h want 55", M_DATA); end
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      M_READY = 1'b0;
      tests++; if (M_VALID !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b want 0", M_VALID); end
      tests++; if (DROP_CNT !== 8'd0) begin fails++; $display("FAIL mid_drop: got %0d want 0", DROP_CNT); end
      tests++; if (FRAME_BINS !== 9'd0) begin fails++; $display("FAIL mid_bins: got %0d want 0", FRAME_BINS); end
      pulse_intr(8'h44);
      pulse_intr(8'h45);
      close_frame();
      tests++; if (FRAME_BINS !== 9'd2) begin fails++; $display("FAIL mid_new_bins: got %0d want 2", FRAME_BINS); end
      collect(0);
      tests++; if (got_n !== 16) begin fails++; $display("FAIL mid_new_count: got %0d want 16", got_n); end
      tests++; if (got_data[0] !== 8'h44 || got_data[1] !== 8'h45 || got_data[2] !== 8'h00) begin
         fails++; $display("FAIL mid_new_data: got %0h,%0h,%0h want 44,45,0", got_data[0], got_data[1], got_data[2]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_drop();
      test_empty_close();
      test_simultaneous();
      test_ready_toggle();
      test_reset_mid_stream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
